// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with per-entry saturating direction counters.
// Zero-latency fetch lookup, resolve-stage update, saturating hit/mispredict statistics.
module branch_target_buffer #(
   parameter int WORD_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              lookup_en,
   input  logic [WORD_W-1:0] fetch_pc,
   output logic              hit,
   output logic              pred_taken,
   output logic [WORD_W-1:0] pred_next_pc,
   input  logic              upd_en,
   input  logic [WORD_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [WORD_W-1:0] upd_target,
   input  logic              upd_jump,
   input  logic              upd_mispredict,
   input  logic              btb_flush,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WORD_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // lookup_en and upd_en are valid-only qualifiers: there is no ready, every
   // presented lookup and update is accepted in the cycle it is valid.

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [WORD_W-1:0]  target_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             u_match;
   logic [CTR_W-1:0] u_ctr;
   logic             unused_pc_lsbs;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[WORD_W-1:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[WORD_W-1:IDX_W+2];
   assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

   // Lookup reads the registered state only, so a same-cycle update is not bypassed.
   assign hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken   = hit && ctr_q[f_idx][CTR_W-1];
   assign pred_next_pc = pred_taken ? target_q[f_idx] : fetch_pc + WORD_W'(4);

   assign u_match = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctr   = ctr_q[u_idx];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (btb_flush) begin
         valid_q <= '0;
      end else if (upd_en) begin
         if (u_match) begin
            if (upd_jump) begin
               ctr_q[u_idx]    <= CTR_MAX;
               target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
               if (u_ctr != CTR_MAX) ctr_q[u_idx] <= u_ctr + CTR_W'(1);
               target_q[u_idx] <= upd_target;
            end else begin
               if (u_ctr != '0) ctr_q[u_idx] <= u_ctr - CTR_W'(1);
            end
         end else if (upd_taken || upd_jump) begin
            // Allocation replaces whatever entry aliases to this index.
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
            ctr_q[u_idx]    <= upd_jump ? CTR_MAX : CTR_WT;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt     <= '0;
         mispred_cnt <= '0;
      end else begin
         if (lookup_en && hit && hit_cnt != CNT_MAX)
            hit_cnt <= hit_cnt + CNT_W'(1);
         // Mispredicts are counted even in a flush cycle that drops the update.
         if (upd_en && upd_mispredict && mispred_cnt != CNT_MAX)
            mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer
// (ENTRIES=16, CNT_W=4 so both statistics counters can be driven into saturation).
module tb_branch_target_buffer;
   logic        CLK;
   logic        nRST;
   logic        lookup_en;
   logic [31:0] fetch_pc;
   logic        hit;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_jump;
   logic        upd_mispredict;
   logic        btb_flush;
   logic [3:0]  hit_cnt;
   logic [3:0]  mispred_cnt;

   int checks = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];

   branch_target_buffer #(.WORD_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(4)) dut (
      .CLK(CLK), .nRST(nRST), .lookup_en(lookup_en), .fetch_pc(fetch_pc),
      .hit(hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_jump(upd_jump),
      .upd_mispredict(upd_mispredict), .btb_flush(btb_flush),
      .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_update(input logic [31:0] pc, input logic taken,
                               input logic [31:0] tgt, input logic jump,
                               input logic mis);
      upd_en = 1'b1; upd_pc = pc; upd_taken = taken;
      upd_target = tgt; upd_jump = jump; upd_mispredict = mis;
   endtask

   task automatic clear_update();
      upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_jump = 1'b0; upd_mispredict = 1'b0;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic jump);
      drive_update(pc, taken, tgt, jump, 1'b0);
      step();
      clear_update();
   endtask

   task automatic look(input logic [31:0] pc);
      fetch_pc = pc;
      #1;
   endtask

   // scenarios
   task automatic test_reset();
      nRST = 1'b0; lookup_en = 1'b0; btb_flush = 1'b0;
      clear_update();
      look(32'h100);
      #2;
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL reset_hit: got %0b want 0", hit); end
      checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h104) begin fails++; $display("FAIL reset_next_pc: got %h want 00000104", pred_next_pc); end
      checks++; if (hit_cnt !== 4'd0) begin fails++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
      checks++; if (mispred_cnt !== 4'd0) begin fails++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); end
      step();
      nRST = 1'b1;
      step();
   endtask

   task automatic test_allocate();
      do_update(32'h100, 1'b1, 32'h80, 1'b0);
      lookup_en = 1'b1;
      look(32'h100);
      checks++; if (hit !== 1'b1) begin fails++; $display("FAIL alloc_hit: got %0b want 1", hit); end
      checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h80) begin fails++; $display("FAIL alloc_next_pc: got %h want 00000080", pred_next_pc); end
      step();
      lookup_en = 1'b0;
      checks++; if (hit_cnt !== 4'd1) begin fails++; $display("FAIL alloc_hit_cnt: got %0d want 1", hit_cnt); end
   endtask

   task automatic test_saturation();
      logic [31:0] exp_pc;
      // counter 10 -> 01 -> 00 -> 00 (not taken), then 01 -> 10 (taken)
      exp_q = {32'h104, 32'h104, 32'h104, 32'h104, 32'h80};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) do_update(32'h100, 1'b0, 32'h0, 1'b0);
         else       do_update(32'h100, 1'b1, 32'h80, 1'b0);
         look(32'h100);
         exp_pc = exp_q.pop_front();
         checks++; if (hit !== 1'b1) begin fails++; $display("FAIL sat_hit[%0d]: got %0b want 1", i, hit); end
         checks++; if (pred_next_pc !== exp_pc) begin fails++; $display("FAIL sat_next_pc[%0d]: got %h want %h", i, pred_next_pc, exp_pc); end
      end
   endtask

   task automatic test_alias();
      look(32'h140);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL alias_pre_hit: got %0b want 0", hit); end
      do_update(32'h140, 1'b1, 32'h200, 1'b0);
      look(32'h140);
      checks++; if (pred_next_pc !== 32'h200) begin fails++; $display("FAIL alias_new_pc: got %h want 00000200", pred_next_pc); end
      look(32'h100);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL alias_old_hit: got %0b want 0", hit); end
      checks++; if (pred_next_pc !== 32'h104) begin fails++; $display("FAIL alias_old_pc: got %h want 00000104", pred_next_pc); end
   endtask

   task automatic test_back_to_back();
      // lookup and update to idx 0 in the same cycle: old target is returned
      drive_update(32'h140, 1'b1, 32'h240, 1'b0, 1'b0);
      look(32'h140);
      checks++; if (pred_next_pc !== 32'h200) begin fails++; $display("FAIL same_cycle_pc: got %h want 00000200", pred_next_pc); end
      step();
      clear_update();
      look(32'h140);
      checks++; if (pred_next_pc !== 32'h240) begin fails++; $display("FAIL after_update_pc: got %h want 00000240", pred_next_pc); end
   endtask

   task automatic test_flush();
      btb_flush = 1'b1;
      drive_update(32'h40, 1'b1, 32'h500, 1'b0, 1'b1);
      step();
      clear_update();
      btb_flush = 1'b0;
      look(32'h40);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL flush_drop_hit: got %0b want 0", hit); end
      checks++; if (pred_next_pc !== 32'h44) begin fails++; $display("FAIL flush_drop_pc: got %h want 00000044", pred_next_pc); end
      look(32'h140);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL flush_clear_hit: got %0b want 0", hit); end
      checks++; if (mispred_cnt !== 4'd1) begin fails++; $display("FAIL flush_mispred_cnt: got %0d want 1", mispred_cnt); end
   endtask

   task automatic test_jump_stats();
      do_update(32'h20, 1'b1, 32'h300, 1'b1);
      look(32'h20);
      checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL jump_pred_taken: got %0b want 1", pred_taken); end
      checks++; if (pred_next_pc !== 32'h300) begin fails++; $display("FAIL jump_next_pc: got %h want 00000300", pred_next_pc); end
      do_update(32'h20, 1'b0, 32'h0, 1'b0);
      look(32'h20);
      checks++; if (pred_next_pc !== 32'h300) begin fails++; $display("FAIL jump_nt1_pc: got %h want 00000300", pred_next_pc); end
      do_update(32'h20, 1'b0, 32'h0, 1'b0);
      look(32'h20);
      checks++; if (pred_next_pc !== 32'h24) begin fails++; $display("FAIL jump_nt2_pc: got %h want 00000024", pred_next_pc); end
      checks++; if (hit !== 1'b1) begin fails++; $display("FAIL jump_nt2_hit: got %0b want 1", hit); end
      // 20 cycles of hits and mispredicts: both counters saturate at 15
      lookup_en = 1'b1;
      drive_update(32'h3C, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step();
      clear_update();
      lookup_en = 1'b0;
      #1;
      checks++; if (mispred_cnt !== 4'd15) begin fails++; $display("FAIL mispred_sat: got %0d want 15", mispred_cnt); end
      checks++; if (hit_cnt !== 4'd15) begin fails++; $display("FAIL hit_sat: got %0d want 15", hit_cnt); end
      look(32'h3C);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL nt_miss_no_alloc: got %0b want 0", hit); end
      look(32'hFFFF_FFFC);
      checks++; if (pred_next_pc !== 32'h0) begin fails++; $display("FAIL pc_wrap: got %h want 00000000", pred_next_pc); end
   endtask

   task automatic test_async_reset();
      look(32'h20);
      checks++; if (hit !== 1'b1) begin fails++; $display("FAIL pre_reset_hit: got %0b want 1", hit); end
      nRST = 1'b0;
      #1;
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL async_hit: got %0b want 0", hit); end
      checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL async_pred_taken: got %0b want 0", pred_taken); end
      checks++; if (pred_next_pc !== 32'h24) begin fails++; $display("FAIL async_next_pc: got %h want 00000024", pred_next_pc); end
      checks++; if (hit_cnt !== 4'd0) begin fails++; $display("FAIL async_hit_cnt: got %0d want 0", hit_cnt); end
      checks++; if (mispred_cnt !== 4'd0) begin fails++; $display("FAIL async_mispred_cnt: got %0d want 0", mispred_cnt); end
      step();
      nRST = 1'b1;
      step();
      look(32'h20);
      checks++; if (hit !== 1'b0) begin fails++; $display("FAIL post_reset_hit: got %0b want 0", hit); end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_saturation();
      test_alias();
      test_back_to_back();
      test_flush();
      test_jump_stats();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
